// File: rtl/rotator_sched.sv
// Round-robin scheduler feeding a shared data rotator: one channel config, then 8 words, then a completion handshake.
// Optional WAIT-state watchdog enabled by defining ROT_SCHED_TIMEOUT_EN.
module rotator_sched #(
    parameter int WORD_SIZE = 128,
    parameter int CH_W      = 5,
    parameter int TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [2*CH_W-1:0]      req_channel,
    input  logic [1:0]             in_valid,
    input  logic [2*WORD_SIZE-1:0] in_data,
    output logic [1:0]             in_ready,
    output logic [1:0]             grant,
    output logic [1:0]             done,
    output logic                   err,
    output logic                   rot_cfg_valid,
    output logic [2:0]             rot_op,
    output logic [7:0]             rot_channel,
    output logic                   rot_di_valid,
    output logic [WORD_SIZE-1:0]   rot_di,
    input  logic                   rot_done
);

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_LOAD, S_WAIT, S_ACK} state_t;

    state_t          state, state_nxt;
    logic            last_grant;
    logic [2:0]      word_cnt;
    logic            err_flag;
    logic [CH_W-1:0] chan_q;
    logic            win;
    logic [CH_W-1:0] win_ch;
    logic            win_bad;
    logic            g_idx;
    logic            accept;
    logic            timed_out;

    always_comb begin
        win     = req_valid[~last_grant] ? ~last_grant : last_grant;
        win_ch  = req_channel[int'(win)*CH_W +: CH_W];
        win_bad = (win_ch == '0) || (win_ch > CH_W'(16));
        g_idx   = grant[1];
        accept  = (state == S_LOAD) && in_valid[g_idx];
    end

`ifdef ROT_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] wait_cnt;

    // Held at zero outside WAIT, so it starts from 0 on every WAIT entry.
    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT) wait_cnt <= '0;
        else                        wait_cnt <= wait_cnt + 1'b1;
    end

    assign timed_out = (state == S_WAIT) && (wait_cnt == TW'(TIMEOUT - 1));
`else
    // WAIT is unbounded in this build; the expression only keeps TIMEOUT referenced.
    assign timed_out = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (|req_valid) state_nxt = win_bad ? S_ACK : S_CFG;
            S_CFG:  state_nxt = S_LOAD;
            S_LOAD: if (accept && word_cnt == 3'd7) state_nxt = S_WAIT;
            S_WAIT: if (rot_done || timed_out) state_nxt = S_ACK;
            S_ACK:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= 1'b1;
            grant        <= '0;
            word_cnt     <= '0;
            err_flag     <= 1'b0;
            chan_q       <= '0;
            rot_di_valid <= 1'b0;
            rot_di       <= '0;
        end else begin
            rot_di_valid <= accept;
            if (accept) rot_di <= in_data[int'(g_idx)*WORD_SIZE +: WORD_SIZE];
            case (state)
                S_IDLE: if (|req_valid) begin
                    grant    <= 2'b01 << win;
                    chan_q   <= win_ch;
                    err_flag <= win_bad;
                    word_cnt <= '0;
                end
                S_LOAD: if (accept) word_cnt <= word_cnt + 1'b1;
                S_WAIT: if (!rot_done && timed_out) err_flag <= 1'b1;
                S_ACK: begin
                    last_grant <= g_idx;
                    grant      <= '0;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state and grant registers.
    always_comb begin
        in_ready      = (state == S_LOAD) ? grant : 2'b00;
        done          = (state == S_ACK)  ? grant : 2'b00;
        err           = (state == S_ACK) && err_flag;
        rot_cfg_valid = (state == S_CFG);
        rot_op        = 3'b000;
        rot_channel   = 8'(chan_q);
    end

endmodule

// File: doc/rotator_sched.md
# rotator_sched

Controller and arbiter for the shared data rotator in the TPU input path. Two requesters (e.g. weight loader, activation loader) compete for the rotator. The block grants one requester at a time round-robin, issues the rotator channel configuration, and streams exactly 8 words of `WORD_SIZE` bits from the granted requester into the rotator. It then waits for the rotator's completion pulse and returns a per-requester done/err pulse.

## Interface
- `WORD_SIZE`, 128: data word width, matching `` `WORD_SIZE ``.
- `CH_W`, 5: channel field width; legal channel values are 1..16.
- `TIMEOUT`, 64: WAIT-state cycle budget, used only with `ROT_SCHED_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk` in 1: the only clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: bit i = requester i wants a rotation; held high until `done[i]`.
- `req_channel` in 2*CH_W: requester i's channel count at bits [i*CH_W +: CH_W].
- `in_valid` in 2: requester i offers a data word.
- `in_data` in 2*WORD_SIZE: requester i's word at bits [i*WORD_SIZE +: WORD_SIZE].
- `in_ready` out 2: one-hot; high only for the granted requester in LOAD.
- `grant` out 2: one-hot registered grant; 0 in IDLE.
- `done` out 2: one-cycle pulse to requester i at job end.
- `err` out 1: qualifies `done`; 1 = job aborted.
- `rot_cfg_valid` out 1: one-cycle configuration strobe to the rotator.
- `rot_op` out 3: always 3'b000 (set channel).
- `rot_channel` out 8: latched channel, zero-extended.
- `rot_di_valid` out 1: registered word strobe to the rotator.
- `rot_di` out WORD_SIZE: registered word to the rotator.
- `rot_done` in 1: rotator completion pulse (its DO_valid on last output).

## Operation
- States: IDLE, CFG, LOAD, WAIT, ACK.
- **IDLE**
  - If any `req_valid`, grant round-robin: priority goes to the requester after `last_grant`; `last_grant` resets to 1, so requester 0 wins first.
  - Latch the granted requester's channel. Go to CFG.
  - If the latched channel is 0 or >16, skip to ACK with `err`=1; the rotator is untouched.
- **CFG**: `rot_cfg_valid`=1, `rot_op`=000, `rot_channel`=latched value, for exactly one cycle. Go to LOAD.
- **LOAD**
  - `in_ready[g]`=1. Each cycle with `in_valid[g]`&&`in_ready[g]`: register the word into `rot_di` with `rot_di_valid`=1 on the next cycle, and increment the 3-bit word counter.
  - On the 8th accepted word (counter wraps 7→0), go to WAIT.
  - `in_valid` from the non-granted requester is ignored.
- **WAIT**: on `rot_done`=1, go to ACK.
- **ACK**
  - `done[g]`=1 for one cycle; `err` per the cause of entry.
  - `last_grant`=g, `grant`=0. Go to IDLE.
- Simultaneous requests: round-robin resolves them. Two back-to-back jobs from the same requester alternate with the other requester whenever both are pending.
- `rot_done` outside WAIT is ignored.
- A requester dropping `req_valid` mid-job has no effect; the job completes.
- Reset in any state:
  - state IDLE, counters 0, `last_grant`=1.
  - All outputs 0: `grant`, `in_ready`, `done`, `err`, `rot_cfg_valid`, `rot_op`, `rot_channel`, `rot_di_valid`, `rot_di`.

## Timing
- Request seen in IDLE at cycle T:
  - `grant` high at T+1 (CFG, `rot_cfg_valid` high).
  - `in_ready` high from T+2.
- With continuous `in_valid`:
  - Words are accepted at T+2..T+9.
  - `rot_di_valid` is high at T+3..T+10.
  - WAIT starts at T+10.
- `rot_done` sampled at cycle W → `done`/`err` high at W+1 → IDLE at W+2. The earliest next grant is visible at W+3.
- Bad-channel request at T: `done`+`err` at T+1.
- All outputs are registered; `in_ready` derives only from state and grant registers.

## Configuration
- `ROT_SCHED_TIMEOUT_EN` defined:
  - WAIT counts cycles from 0. If `rot_done` is not seen by count `TIMEOUT`-1, go to ACK with `err`=1.
  - The counter clears on entry to WAIT.
- Undefined: WAIT has no bound, and `err` is set only for an illegal channel. The counter logic is absent.

## Test plan
- Single job: req0, channel 16, 8 back-to-back words 0x01..0x08, `rot_done` 5 cycles after WAIT entry → one `rot_cfg_valid` with `rot_channel`=16; `rot_di` carries 0x01..0x08 in order; `done`=2'b01, `err`=0.
- Contention: `req_valid`=2'b11 after reset, channel 8 each, two full jobs → first `grant`=01, then 10; neither requester is granted twice in a row.
- Throttled input: `in_valid[0]` toggles every other cycle → exactly 8 `rot_di_valid` pulses; the data order is preserved; `in_ready` stays high until the 8th acceptance.
- Illegal channel: req1 with channel 0, then with channel 17 → `done`=2'b10 and `err`=1 one cycle after each request; `rot_cfg_valid` and `rot_di_valid` never assert.
- Reset mid-LOAD after 3 words → the next cycle all outputs are 0 and the state is IDLE; a subsequent req1 and req0 together grant req0 first.
- Timeout (with macro, `TIMEOUT`=64): no `rot_done` → `done` plus `err`=1 exactly 64 cycles after WAIT entry. Without the macro, `grant` stays held after 200 cycles.
